pipe_addsub: RTL and testbench
==============================

Name: pipe_addsub

Overview:
- Parametrised, pipelined successor to the combinational adder in the CPU datapath.
- Computes W-bit add or subtract with carry-in, split into SEG-bit slices with one register stage per slice.
- Carry ripples stage to stage. Result emerges with carry-out, signed overflow and zero flags.
- Valid/ready handshake at both ends lets the ALU or multi-cycle units stall it.

Parameters:
W, 32, operand/result width; must be a multiple of SEG.
SEG, 8, slice width per pipeline stage; STAGES = W/SEG (SEG = W gives a single stage).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand beat present.
in_ready  out  1  block accepts a beat this cycle.
in0  in  W  operand A.
in1  in  W  operand B.
cin  in  1  carry-in for add, borrow-in for subtract.
sub  in  1  0 = A+B+cin, 1 = A-B-cin.
out_valid  out  1  result beat present.
out_ready  in  1  downstream accepts the result.
sum  out  W  result.
cout  out  1  raw carry out of the MSB.
ovf  out  1  signed two's-complement overflow.
zero  out  1  sum == 0.

Behaviour:
- Reset (async, any time):
  - All stage valid bits and all data/flag registers clear to 0.
  - out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - In-flight beats are discarded. in_ready=1 after reset deasserts.
- Operand conditioning at acceptance:
  - b = sub ? ~in1 : in1.
  - c0 = sub ? ~cin : cin.
  - Subtract is therefore A + ~B + ~cin. With cin=0 this is A-B; cout=1 means no borrow.
- Global advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - Every stage register loads only when adv=1. All stages move in lockstep; bubbles are not collapsed.
  - A beat is accepted when in_valid & in_ready.
- Stage k (0..STAGES-1):
  - Adds slice k of A and b plus the carry from stage k-1 (c0 for k=0).
  - Registers the SEG-bit partial sum, its carry, the already-computed lower slices, and the not-yet-added upper slices of A and b.
  - Upper slices are skewed along the pipe; no slice is added twice.
  - Each stage carries a valid bit; stage k valid loads stage k-1 valid (in_valid & in_ready for k=0).
- Final stage outputs:
  - sum = concatenated slices; cout = carry from the top slice.
  - ovf = (A[W-1] == b[W-1]) & (sum[W-1] != A[W-1]), using conditioned b. The operand MSBs travel with the beat.
  - zero = (sum == 0), registered in the final stage, not combinational on the output.
- Latency and throughput:
  - Exactly STAGES cycles from acceptance to out_valid with out_ready held high.
  - Throughput 1 beat/cycle.
- Stall: out_valid & ~out_ready holds every stage and every output stable, and drives in_ready=0. Input values are ignored while in_ready=0.
- Accept and drain in the same cycle (out_valid & out_ready & in_valid): allowed, no bubble inserted.
- Wrap-around: unsigned overflow wraps modulo 2^W and is reported only via cout/ovf.
- in_valid=0 with adv=1 inserts a bubble: valid bits shift, data registers may load don't-care values, and outputs are meaningful only when out_valid=1.

Test Plan:
1. Reset, then W=32/SEG=8: in0=0x0000_0001, in1=0x0000_0002, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles after acceptance; sum=0x0000_0003, cout=0, ovf=0, zero=0.
2. Cross-slice carry ripple: in0=0xFFFF_FFFF, in1=0x0000_0001, add -> sum=0, cout=1, ovf=0, zero=1.
3. Subtract and signed overflow:
   - 0x8000_0000 - 0x0000_0001 (sub=1, cin=0) -> sum=0x7FFF_FFFF, cout=1, ovf=1.
   - 5-7 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
   - 7-5 with cin=1 -> sum=1.
4. Back-to-back stream of 8 random beats with out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching the reference model (A±B±cin).
5. Backpressure: stream 6 beats, drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, outputs frozen, no beat lost or duplicated, order preserved.
6. Assert rst while 3 beats are in flight -> out_valid falls to 0 immediately (async). After release, no stale beat appears; a new beat 0x10+0x20 yields 0x30 after 4 cycles.

Source files
------------

// File: rtl/pipe_addsub.sv
// Pipelined W-bit adder/subtractor: one SEG-bit slice per register stage, carry rippling
// stage to stage, with valid/ready flow control and carry/overflow/zero flags on the result.
module pipe_addsub #(
    parameter int W   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int STAGES = W / SEG;
    localparam int LAST   = STAGES - 1;

    logic         adv;
    logic [W-1:0] bcond;
    logic         c0;

    // Per-stage registers. acc holds finished sum slices below the stage boundary and
    // still-unadded slices of A above it; bsh holds operand B shifted so its next slice sits at bit 0.
    logic         v_q   [STAGES];
    logic         c_q   [STAGES];
    logic         am_q  [STAGES];
    logic         bm_q  [STAGES];
    logic [W-1:0] acc_q [STAGES];
    logic [W-1:0] bsh_q [STAGES];
    logic         zero_q;

    logic         v_in   [STAGES];
    logic         c_in   [STAGES];
    logic         am_in  [STAGES];
    logic         bm_in  [STAGES];
    logic [W-1:0] a_in   [STAGES];
    logic [W-1:0] b_in   [STAGES];
    logic [SEG:0] part   [STAGES];
    logic [W-1:0] acc_nxt[STAGES];

    assign adv      = ~v_q[LAST] | out_ready;
    assign in_ready = adv;
    assign bcond    = sub ? ~in1 : in1;
    assign c0       = sub ? ~cin : cin;

    // Stage inputs: stage 0 takes the conditioned operands, later stages take their predecessor.
    always_comb begin
        v_in[0]  = in_valid & in_ready;
        c_in[0]  = c0;
        am_in[0] = in0[W-1];
        bm_in[0] = bcond[W-1];
        a_in[0]  = in0;
        b_in[0]  = bcond;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k]  = v_q[k-1];
            c_in[k]  = c_q[k-1];
            am_in[k] = am_q[k-1];
            bm_in[k] = bm_q[k-1];
            a_in[k]  = acc_q[k-1];
            b_in[k]  = bsh_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][SEG-1:0]}
                    + {{SEG{1'b0}}, c_in[k]};
            acc_nxt[k] = a_in[k];
            acc_nxt[k][k*SEG +: SEG] = part[k][SEG-1:0];
        end
    end

    // All stages advance in lockstep on adv; a stalled output freezes the whole pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                c_q[k]   <= 1'b0;
                am_q[k]  <= 1'b0;
                bm_q[k]  <= 1'b0;
                acc_q[k] <= '0;
                bsh_q[k] <= '0;
            end
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= v_in[k];
                c_q[k]   <= part[k][SEG];
                am_q[k]  <= am_in[k];
                bm_q[k]  <= bm_in[k];
                acc_q[k] <= acc_nxt[k];
                bsh_q[k] <= b_in[k] >> SEG;
            end
            zero_q <= (acc_nxt[LAST] == '0);
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = acc_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = (am_q[LAST] == bm_q[LAST]) & (acc_q[LAST][W-1] != am_q[LAST]);
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed-vector bench for pipe_addsub (W=32, SEG=8): reset, arithmetic corners,
// streaming, backpressure and mid-flight reset, with a FIFO scoreboard on the output side.
module tb_pipe_addsub;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int   tests_run  = 0;
    int   tests_fail = 0;
    int   cycle      = 0;
    int   out_count  = 0;
    int   first_out  = 0;
    int   last_out   = 0;
    bit   lat_check  = 1'b1;
    exp_t exp_q[$];

    pipe_addsub #(.W(32), .SEG(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.acc_cyc = 0; e.lat = 1'b1;
        return e;
    endfunction

    // Reference: plain 33-bit add or subtract; cout is carry for add and not-borrow for subtract.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic s);
        logic [32:0] r;
        exp_t e;
        if (!s) begin
            r = {1'b0, a} + {1'b0, b} + 33'(c);
            e = mk(r[31:0], r[32], (a[31] == b[31]) && (r[31] != a[31]), r[31:0] == 0);
        end else begin
            r = {1'b0, a} - {1'b0, b} - 33'(c);
            e = mk(r[31:0], ~r[32], (a[31] != b[31]) && (r[31] != a[31]), r[31:0] == 0);
        end
        return e;
    endfunction

    // Called just after a rising edge; holds the beat until accepted, returns just after that edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s, input exp_t e);
        int guard;
        guard    = 0;
        in0      = a;
        in1      = b;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        e.acc_cyc = cycle;
        e.lat     = lat_check;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Output-side scoreboard: every transferred beat must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sum", 64'(sum), 64'(e.sum));
                checkOutput("cout", 64'(cout), 64'(e.cout));
                checkOutput("ovf", 64'(ovf), 64'(e.ovf));
                checkOutput("zero", 64'(zero), 64'(e.zero));
                if (e.lat) checkOutput("latency", 64'(cycle - e.acc_cyc), 64'd4);
                out_count++;
                if (out_count == 1) first_out = cycle;
                last_out = cycle;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] sa, sb;
        logic [31:0] cap_sum;
        logic        cap_cout;
        logic        sc, ss;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in0       = '0;
        in1       = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);
        checkOutput("rst_zero", 64'(zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic add, cross-slice ripple, subtract and overflow corners (issued back to back).
        applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, mk(32'h0000_0003, 1'b0, 1'b0, 1'b0));
        drain();
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        applyStimulus(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, mk(32'h0000_0001, 1'b1, 1'b0, 1'b0));
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        applyStimulus(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, mk(32'h0100_0101, 1'b0, 1'b0, 1'b0));
        applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        drain();

        // Back-to-back stream of 8 random beats.
        out_count = 0;
        for (int i = 0; i < 8; i++) begin
            sa = $urandom;
            sb = $urandom;
            sc = 1'($urandom_range(0, 1));
            ss = 1'($urandom_range(0, 1));
            applyStimulus(sa, sb, sc, ss, model(sa, sb, sc, ss));
        end
        drain();
        checkOutput("stream_count", 64'(out_count), 64'd8);
        checkOutput("stream_span", 64'(last_out - first_out), 64'd7);

        // Backpressure: out_ready low for 3 cycles while beats are still being offered.
        out_count = 0;
        lat_check = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    sa = $urandom;
                    sb = $urandom;
                    sc = 1'($urandom_range(0, 1));
                    ss = 1'($urandom_range(0, 1));
                    applyStimulus(sa, sb, sc, ss, model(sa, sb, sc, ss));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                cap_sum  = sum;
                cap_cout = cout;
                checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
                checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
                    checkOutput("stall_sum_frozen", 64'(sum), 64'(cap_sum));
                    checkOutput("stall_cout_frozen", 64'(cout), 64'(cap_cout));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checkOutput("stall_count", 64'(out_count), 64'd6);
        lat_check = 1'b1;

        // Reset with beats in flight: nothing stale may emerge afterwards.
        applyStimulus(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, mk(32'h0000_0300, 1'b0, 1'b0, 1'b0));
        applyStimulus(32'h0000_0101, 32'h0000_0200, 1'b0, 1'b0, mk(32'h0000_0301, 1'b0, 1'b0, 1'b0));
        applyStimulus(32'h0000_0102, 32'h0000_0200, 1'b0, 1'b0, mk(32'h0000_0302, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #2;
        checkOutput("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_sum", 64'(sum), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("stale_beat", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, mk(32'h0000_0030, 1'b0, 1'b0, 1'b0));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
